// File: rtl/core_muldiv_seq.sv
// RV M-extension unit: pipelined multiplier (MUL_STAGES deep) + radix-2 restoring divider.
// Latency: MUL* T+MUL_STAGES, DIV/REM T+XLEN+1, div-by-zero/overflow (and cache hit) T+1.
// Backpressure: result holds in DONE until ready_i; ready_o is low whenever not IDLE.
// Ports: clk_i/rst_ni (async active-low); request valid_i/ready_o/op_i/in1_i/in2_i;
//        kill_i flush; response valid_o/ready_i/result_o; busy_o = not IDLE.
// Optional: define MULDIV_REM_CACHE_EN to reuse the last divide's quotient/remainder.
module core_muldiv_seq #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] in1_i,
  input  logic [XLEN-1:0] in2_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam int               CW       = $clog2(XLEN);
  localparam logic [CW-1:0]    DIV_LAST = CW'(XLEN-1);
  localparam logic [CW-1:0]    MUL_LAST = CW'((MUL_STAGES > 1) ? MUL_STAGES-2 : 0);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES = '1;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a, r_b;          // operands as captured at accept
  logic [XLEN-1:0]   r_quo, r_rem, r_dvs;
  logic              r_neg_q, r_neg_r;
  logic [XLEN-1:0]   r_result;

  // ---------------- request decode (IDLE only) ----------------
  logic            w_acc, w_dsgn, w_dz, w_ovf, w_neg1, w_neg2;
  logic [XLEN-1:0] w_abs1, w_abs2, w_spec_res;

  assign w_acc      = (r_state == S_IDLE) && valid_i && !kill_i;
  assign w_dsgn     = ~op_i[0];                       // DIV/REM signed, DIVU/REMU not
  assign w_dz       = (in2_i == '0);
  assign w_ovf      = w_dsgn && (in1_i == MIN_NEG) && (in2_i == ALL_ONES);
  assign w_spec_res = w_dz ? (op_i[1] ? in1_i : ALL_ONES)
                           : (op_i[1] ? '0    : in1_i);
  assign w_neg1     = w_dsgn & in1_i[XLEN-1];
  assign w_neg2     = w_dsgn & in2_i[XLEN-1];
  assign w_abs1     = w_neg1 ? -in1_i : in1_i;
  assign w_abs2     = w_neg2 ? -in2_i : in2_i;

  // ---------------- multiplier ----------------
  // Operands come straight from the ports in IDLE so MUL_STAGES=1 can finish at T+1;
  // deeper settings hold them in r_a/r_b and leave the product path for retiming.
  logic [2:0]        w_mop;
  logic [XLEN-1:0]   w_ma, w_mb, w_mul_res;
  logic              w_sa, w_sb;
  logic [2*XLEN-1:0] w_ma_ext, w_mb_ext, w_prod;

  assign w_mop    = (r_state == S_IDLE) ? op_i  : r_op;
  assign w_ma     = (r_state == S_IDLE) ? in1_i : r_a;
  assign w_mb     = (r_state == S_IDLE) ? in2_i : r_b;
  assign w_sa     = (w_mop == 3'd1) || (w_mop == 3'd2);
  assign w_sb     = (w_mop == 3'd1);
  // Extending to 2*XLEN then multiplying modulo 2^(2*XLEN) yields the exact
  // signed/unsigned product for every operand-sign combination.
  assign w_ma_ext = {{XLEN{w_sa & w_ma[XLEN-1]}}, w_ma};
  assign w_mb_ext = {{XLEN{w_sb & w_mb[XLEN-1]}}, w_mb};
  assign w_prod   = w_ma_ext * w_mb_ext;
  assign w_mul_res = (w_mop[1:0] == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // ---------------- divider step ----------------
  logic [XLEN:0]   w_rem_sh, w_diff;
  logic [XLEN-1:0] w_q_nxt, w_r_nxt, w_q_fix, w_r_fix, w_div_res;

  assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_dvs};
  assign w_q_nxt   = {r_quo[XLEN-2:0], ~w_diff[XLEN]};
  assign w_r_nxt   = w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
  assign w_q_fix   = r_neg_q ? -w_q_nxt : w_q_nxt;
  assign w_r_fix   = r_neg_r ? -w_r_nxt : w_r_nxt;
  assign w_div_res = r_op[1] ? w_r_fix : w_q_fix;

  // ---------------- optional result cache ----------------
  logic            w_hit;
  logic [XLEN-1:0] w_hit_res;
`ifdef MULDIV_REM_CACHE_EN
  logic            r_c_vld, r_c_sgn;
  logic [XLEN-1:0] r_c_a, r_c_b, r_c_q, r_c_r;

  assign w_hit     = r_c_vld && op_i[2] && (in1_i == r_c_a) && (in2_i == r_c_b)
                     && (w_dsgn == r_c_sgn);
  assign w_hit_res = op_i[1] ? r_c_r : r_c_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_c_vld <= 1'b0;
      r_c_sgn <= 1'b0;
      r_c_a   <= '0;
      r_c_b   <= '0;
      r_c_q   <= '0;
      r_c_r   <= '0;
    end else if (r_state == S_DIV && r_cnt == DIV_LAST && !kill_i) begin
      r_c_vld <= 1'b1;
      r_c_sgn <= ~r_op[0];
      r_c_a   <= r_a;
      r_c_b   <= r_b;
      r_c_q   <= w_q_fix;
      r_c_r   <= w_r_fix;
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_hit_res = '0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready_o     = 1'b0;
    valid_o     = 1'b0;
    busy_o      = 1'b1;
    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
        if (valid_i) begin
          if (!op_i[2])                 w_state_nxt = (MUL_STAGES == 1) ? S_DONE : S_MUL;
          else if (w_dz || w_ovf || w_hit) w_state_nxt = S_DONE;
          else                          w_state_nxt = S_DIV;
        end
      end
      S_MUL:  if (r_cnt == MUL_LAST) w_state_nxt = S_DONE;
      S_DIV:  if (r_cnt == DIV_LAST) w_state_nxt = S_DONE;
      S_DONE: begin
        valid_o = 1'b1;
        if (ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Flush wins everywhere, including a request presented in IDLE.
    if (kill_i) w_state_nxt = S_IDLE;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (w_acc) begin
      r_op    <= op_i;
      r_a     <= in1_i;
      r_b     <= in2_i;
      r_cnt   <= '0;
      r_quo   <= w_abs1;
      r_rem   <= '0;
      r_dvs   <= w_abs2;
      r_neg_q <= w_neg1 ^ w_neg2;
      r_neg_r <= w_neg1;
      if (!op_i[2]) begin
        if (MUL_STAGES == 1) r_result <= w_mul_res;
      end else if (w_dz || w_ovf) begin
        r_result <= w_spec_res;
      end else if (w_hit) begin
        r_result <= w_hit_res;
      end
    end else if (r_state == S_MUL) begin
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == MUL_LAST) r_result <= w_mul_res;
    end else if (r_state == S_DIV) begin
      r_cnt <= r_cnt + CW'(1);
      r_quo <= w_q_nxt;
      r_rem <= w_r_nxt;
      if (r_cnt == DIV_LAST) r_result <= w_div_res;
    end
  end

  assign result_o = r_result;

endmodule

// File: tb/tb_core_muldiv_seq.sv
// Bench for core_muldiv_seq (XLEN=32, MUL_STAGES=3): directed vector table plus
// kill / mid-op reset / back-pressure sequences.
// Latency is counted from the accepting edge; outputs are sampled on the falling edge.
module tb_core_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0, ready_o, kill_i = 1'b0, valid_o, ready_i = 1'b1, busy_o;
  logic [2:0]  op_i = '0;
  logic [31:0] in1_i = '0, in2_i = '0, result_o;

  int n_pass = 0;
  int n_tot  = 0;

`ifdef MULDIV_REM_CACHE_EN
  localparam int LAT_HIT = 1;
`else
  localparam int LAT_HIT = 33;
`endif

  always #5 clk = ~clk;

  core_muldiv_seq #(.XLEN(32), .MUL_STAGES(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .in1_i(in1_i), .in2_i(in2_i), .kill_i(kill_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .busy_o(busy_o)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Wait for ready_o, present one request, let it be accepted, then scramble operands.
  // Returns at the falling edge of cycle T+1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    @(negedge clk);
    while (!ready_o && w < 200) begin @(negedge clk); w++; end
    check("ready_before_issue", {31'd0, ready_o}, 32'd1);
    valid_i = 1'b1; op_i = op; in1_i = a; in2_i = b;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0; in1_i = $urandom; in2_i = $urandom; op_i = 3'($urandom);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    issue(op, a, b);
    lat = 1;
    while (!valid_o && lat < 100) begin @(negedge clk); lat++; end
    res = result_o;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] res;
    int          lat;
    bit          seen;

    // op codes: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
    vecs.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 3});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 3});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 3});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, LAT_HIT});
    vecs.push_back('{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 33});
    vecs.push_back('{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1});
    vecs.push_back('{3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});
    vecs.push_back('{3'd0, 32'h0000_0003, 32'h0000_0004, 32'h0000_000C, 3});
    vecs.push_back('{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33});
    vecs.push_back('{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, LAT_HIT});
    vecs.push_back('{3'd4, 32'd100,       32'd7,         32'd14,        33});
    vecs.push_back('{3'd6, 32'd100,       32'd7,         32'd2,         LAT_HIT});
    vecs.push_back('{3'd7, 32'd100,       32'd7,         32'd2,         33});

    repeat (3) @(negedge clk);
    check("rst_valid_o", {31'd0, valid_o}, 32'd0);
    check("rst_ready_o", {31'd0, ready_o}, 32'd1);
    check("rst_busy_o",  {31'd0, busy_o},  32'd0);
    check("rst_result_o", result_o, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // ---- kill at T+10 ----
    issue(3'd4, 32'd100, 32'd7);              // now at T+1
    seen = 1'b0;
    for (int c = 1; c < 10; c++) begin seen |= valid_o; @(negedge clk); end
    seen |= valid_o;
    kill_i = 1'b1;                            // cycle T+10
    @(negedge clk);
    kill_i = 1'b0;                            // cycle T+11
    check("kill_ready_T11", {31'd0, ready_o}, 32'd1);
    check("kill_busy_T11",  {31'd0, busy_o},  32'd0);
    for (int c = 0; c < 40; c++) begin seen |= valid_o; @(negedge clk); end
    check("kill_no_valid", {31'd0, seen}, 32'd0);
    run_op(3'd0, 32'd3, 32'd4, res, lat);
    check("post_kill_mul", res, 32'd12);
    check("post_kill_lat", 32'(lat), 32'd3);

    // ---- reset at T+10 ----
    issue(3'd4, 32'd100, 32'd7);
    seen = 1'b0;
    for (int c = 1; c < 10; c++) begin seen |= valid_o; @(negedge clk); end
    seen |= valid_o;
    rst_n = 1'b0;
    #1;
    check("rst_mid_result", result_o, 32'd0);
    check("rst_mid_ready",  {31'd0, ready_o}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready_T11", {31'd0, ready_o}, 32'd1);
    for (int c = 0; c < 40; c++) begin seen |= valid_o; @(negedge clk); end
    check("rst_no_valid", {31'd0, seen}, 32'd0);
    run_op(3'd0, 32'd3, 32'd4, res, lat);
    check("post_rst_mul", res, 32'd12);
    check("post_rst_lat", 32'(lat), 32'd3);

    // ---- back-pressure hold ----
    @(negedge clk);
    ready_i = 1'b0;
    run_op(3'd0, 32'd6, 32'd7, res, lat);
    check("bp_lat", 32'(lat), 32'd3);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold%0d_result", c), result_o, 32'd42);
      check($sformatf("bp_hold%0d_valid", c), {31'd0, valid_o}, 32'd1);
      check($sformatf("bp_hold%0d_ready_o", c), {31'd0, ready_o}, 32'd0);
      check($sformatf("bp_hold%0d_busy", c), {31'd0, busy_o}, 32'd1);
      @(negedge clk);
    end
    check("bp_cycle6_valid", {31'd0, valid_o}, 32'd1);
    ready_i = 1'b1;
    @(negedge clk);
    check("bp_idle_valid", {31'd0, valid_o}, 32'd0);
    check("bp_idle_ready", {31'd0, ready_o}, 32'd1);
    check("bp_idle_busy",  {31'd0, busy_o},  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
